// File: rtl/traffic_light_ctrl_pkg.sv
// Shared state encoding, lamp patterns and lamp decode for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Main-road lamp pattern for a given state; anything not main-green/yellow is red.
  function automatic logic [2:0] main_lamp(state_e s);
    unique case (s)
      MAIN_GREEN:  return LAMP_G;
      MAIN_YELLOW: return LAMP_Y;
      default:     return LAMP_R;
    endcase
  endfunction

  // Side-road lamp pattern for a given state.
  function automatic logic [2:0] side_lamp(state_e s);
    unique case (s)
      SIDE_GREEN:  return LAMP_G;
      SIDE_YELLOW: return LAMP_Y;
      default:     return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Bundles the controller's control inputs and lamp/debug outputs.
interface traffic_light_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clk_div;
  logic             en;
  logic             ped_req;
  logic [2:0]       main_lights;
  logic [2:0]       side_lights;
  logic             walk;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       state_o;

  modport master (
    output clk_div, en, ped_req,
    input  main_lights, side_lights, walk, remaining, state_o
  );

  modport slave (
    input  clk_div, en, ped_req,
    output main_lights, side_lights, walk, remaining, state_o
  );
endinterface

// File: rtl/traffic_light_ctrl_edge_tick.sv
// Turns rising edges of the slow clk_div wave into one-cycle ticks in the clk domain.
module edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  input  logic en,
  output logic tick
);

  logic clk_div_q;

  // Delayed copy of clk_div; keeps tracking even while en is low, so edges seen then are lost.
  always_ff @(posedge clk) begin
    if (!rst) clk_div_q <= 1'b0;
    else      clk_div_q <= clk_div;
  end

  assign tick = en & clk_div & ~clk_div_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light FSM with pedestrian walk insertion, advanced by clk_div ticks.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_MG     = 10,
  parameter int unsigned T_MG_MIN = 4,
  parameter int unsigned T_MY     = 3,
  parameter int unsigned T_AR     = 1,
  parameter int unsigned T_SG     = 6,
  parameter int unsigned T_SY     = 3,
  parameter int unsigned T_WALK   = 5,
  parameter int unsigned CNT_W    = 8
) (
  input logic                clk,
  input logic                rst,
  traffic_light_ctrl_if.slave bus
);

  // Main green may be cut short once the countdown is at or below this value.
  localparam logic [CNT_W-1:0] PED_CUT = CNT_W'(T_MG - T_MG_MIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic [2:0]       main_q, main_d;
  logic [2:0]       side_q, side_d;
  logic             walk_q, walk_d;
  logic             tick;
  logic             leave;
  state_e           next_state;

  edge_tick u_edge_tick (
    .clk     (clk),
    .rst     (rst),
    .clk_div (bus.clk_div),
    .en      (bus.en),
    .tick    (tick)
  );

  // Countdown load value on entry to a state.
  function automatic logic [CNT_W-1:0] load_of(state_e s);
    unique case (s)
      MAIN_GREEN:  return CNT_W'(T_MG - 1);
      MAIN_YELLOW: return CNT_W'(T_MY - 1);
      ALL_RED_A:   return CNT_W'(T_AR - 1);
      PED_WALK:    return CNT_W'(T_WALK - 1);
      SIDE_GREEN:  return CNT_W'(T_SG - 1);
      SIDE_YELLOW: return CNT_W'(T_SY - 1);
      default:     return CNT_W'(T_AR - 1);
    endcase
  endfunction

  // Exit condition and successor of the current state.
  always_comb begin
    leave      = (cnt_q == '0);
    next_state = ALL_RED_B;
    unique case (state_q)
      MAIN_GREEN: begin
        leave      = (cnt_q == '0) || (ped_pending_q && (cnt_q <= PED_CUT));
        next_state = MAIN_YELLOW;
      end
      MAIN_YELLOW: next_state = ALL_RED_A;
      ALL_RED_A:   next_state = ped_pending_q ? PED_WALK : SIDE_GREEN;
      PED_WALK:    next_state = SIDE_GREEN;
      SIDE_GREEN:  next_state = SIDE_YELLOW;
      SIDE_YELLOW: next_state = ALL_RED_B;
      ALL_RED_B:   next_state = MAIN_GREEN;
      default: begin
        leave      = 1'b1;
        next_state = ALL_RED_B;
      end
    endcase
  end

  // Next state, countdown, pedestrian latch and lamp decode of the upcoming state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (leave) begin
        state_d = next_state;
        cnt_d   = load_of(next_state);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    // Entering PED_WALK services the request; that clear beats a same-cycle press.
    if (state_d == PED_WALK && state_q != PED_WALK) ped_pending_d = 1'b0;
    else                                            ped_pending_d = ped_pending_q | bus.ped_req;
    main_d = main_lamp(state_d);
    side_d = side_lamp(state_d);
    walk_d = (state_d == PED_WALK);
  end

  // State, countdown, latch and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ALL_RED_B;
      cnt_q         <= CNT_W'(T_AR - 1);
      ped_pending_q <= 1'b0;
      main_q        <= LAMP_R;
      side_q        <= LAMP_R;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      main_q        <= main_d;
      side_q        <= side_d;
      walk_q        <= walk_d;
    end
  end

  assign bus.main_lights = main_q;
  assign bus.side_lights = side_q;
  assign bus.walk        = walk_q;
  assign bus.remaining   = cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Downstream consumer of the clock divider's slow square wave `clk_div`.
- Rising-edge detects `clk_div` in the fast `clk` domain to form a one-cycle tick.
- On each tick, advances a two-road traffic-light state machine with pedestrian-walk insertion.
- Drives lamp outputs and a countdown display value. Single clock domain; `clk_div` is treated as data, never as a clock.

Parameters:
- T_MG, 10, main-road green duration in ticks
- T_MG_MIN, 4, minimum main green before a pending pedestrian request cuts it short (1..T_MG)
- T_MY, 3, main-road yellow duration in ticks
- T_AR, 1, all-red clearance duration in ticks
- T_SG, 6, side-road green duration in ticks
- T_SY, 3, side-road yellow duration in ticks
- T_WALK, 5, pedestrian walk duration in ticks
- CNT_W, 8, countdown width; every duration must satisfy 1 <= T <= 2^CNT_W

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-low reset
- clk_div, in, 1, slow square wave from the divider, same clock domain
- en, in, 1, 1 = ticks advance the FSM; 0 = freeze state and countdown
- ped_req, in, 1, pedestrian button, level or pulse, sampled every clk
- main_lights, out, 3, {red, yellow, green} for the main road, one-hot
- side_lights, out, 3, {red, yellow, green} for the side road, one-hot
- walk, out, 1, pedestrian walk lamp
- remaining, out, CNT_W, ticks left in the current state minus one
- state_o, out, 3, current state encoding for debug

Behaviour:
- Reset is synchronous, sampled when rst==0 at a posedge clk. Reset values:
  - state = ALL_RED_B, cnt = T_AR-1, clk_div_q = 0, ped_pending = 0
  - main_lights = 3'b100, side_lights = 3'b100, walk = 0
- Tick:
  - clk_div_q <= clk_div every cycle.
  - tick = en & clk_div & ~clk_div_q, combinational, so exactly one tick per clk_div rising edge.
  - The divider also resets clk_div to 0, so no spurious tick occurs after reset.
  - Falling edges of clk_div are ignored.
- States and transitions (all taken only on a tick):
  - MAIN_GREEN: main G, side R. Leave to MAIN_YELLOW when cnt==0, or when ped_pending && cnt <= T_MG-T_MG_MIN. With defaults, a pending request yields exactly 4 ticks of green.
  - MAIN_YELLOW: main Y, side R. Leave to ALL_RED_A at cnt==0.
  - ALL_RED_A: both R. At cnt==0, go to PED_WALK if ped_pending, else SIDE_GREEN.
  - PED_WALK: both R, walk=1. Leave to SIDE_GREEN at cnt==0.
  - SIDE_GREEN: main R, side G. Leave to SIDE_YELLOW at cnt==0.
  - SIDE_YELLOW: main R, side Y. Leave to ALL_RED_B at cnt==0.
  - ALL_RED_B: both R. Leave to MAIN_GREEN at cnt==0.
- Countdown:
  - On entering a state, cnt <= T_state-1.
  - On a tick without a transition, cnt <= cnt-1.
  - With no tick, cnt holds.
  - cnt never wraps, because a transition always occurs at 0.
  - remaining = cnt.
- Pedestrian latch:
  - ped_pending is set in any cycle where ped_req==1.
  - It is cleared in the cycle the FSM enters PED_WALK; the clear wins over a simultaneous ped_req.
  - ped_req asserted during PED_WALK is latched and serviced on the next cycle through the sequence.
- en=0 freezes state, cnt and outputs, but ped_pending still latches and clk_div_q still tracks clk_div.
  - A clk_div rise that occurs while en=0 is lost; it is not deferred.
- Outputs are registered and decoded from the state register.
  - Lamps change in the cycle after the tick edge.
  - Green is never active on both roads at once.
  - walk=1 only while both roads are red.
- Reset mid-operation: on the next posedge, return to the reset values above; a pending request is discarded.

Decomposition:
- Package traffic_pkg holds:
  - state enum: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, PED_WALK=3, SIDE_GREEN=4, SIDE_YELLOW=5, ALL_RED_B=6
  - lamp constants: LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001
- One sub-module, edge_tick, contains:
  - the clk_div_q register, the en gating and the rising-edge pulse
  - the same synchronous active-low rst
- FSM, countdown and pedestrian latch stay in the top module.

Test Plan:
- Release reset, no ped_req, with clk_div toggling every 4 clk:
  - Sequence is ALL_RED_B(1 tick) → MAIN_GREEN(10) → MAIN_YELLOW(3) → ALL_RED_A(1) → SIDE_GREEN(6) → SIDE_YELLOW(3) → ALL_RED_B(1).
  - remaining counts 9..0 in MAIN_GREEN.
- Pulse ped_req for 1 clk during the 2nd MAIN_GREEN tick:
  - MAIN_GREEN lasts exactly 4 ticks, then MAIN_YELLOW → ALL_RED_A → PED_WALK (walk=1 for 5 ticks) → SIDE_GREEN.
  - ped_pending is 0 after entering PED_WALK.
- Assert ped_req only after MAIN_GREEN cnt has already reached 6 or less:
  - MAIN_YELLOW entered on the very next tick.
- Hold en=0 for 3 clk_div periods mid SIDE_GREEN, with remaining=3:
  - State and remaining stay frozen.
  - After en=1, SIDE_GREEN continues for 4 more ticks.
- Assert rst=0 for 1 clk during PED_WALK:
  - Next cycle: state=ALL_RED_B, remaining=0, walk=0, both lamps 3'b100.
- Hold clk_div high for 20 clk:
  - Exactly one tick is produced.
  - Assertion: no overlap of main G with side G, and walk=1 only while both roads are red, checked every cycle across all runs.
